axis_packet_dispatcher_fsm: RTL and testbench
=============================================

Name: axis_packet_dispatcher_fsm

Overview:
- Control stage directly upstream of the dispatcher demultiplexeur; generates the `state` vector that steers data to the parser or the multiplexeur.
- Sequences each AXI-Stream packet: header capture, parser decision, analysed-data emission, pass-through of the remainder, or drop.
- Owns all s_axis/m_axis handshake qualifiers (tready, tvalid, tlast). Datapath tdata is not handled here.
- Maintains packet and drop counters.

Parameters:
- STATE_WIDTH, 3, width of state output
- IDLE/PARSE_DATA/CONTROL/SEND_ANALYSED_DATA/SEND_REMAIN/DROP, 0/1/2/3/4/5, state encodings shared with the demultiplexeur
- HEADER_WORDS, 4, max beats routed to the parser per packet (>=1)
- ANALYSED_WORDS, 2, beats emitted in SEND_ANALYSED_DATA (>=1)
- CONTROL_TIMEOUT, 64, cycles allowed in CONTROL before forced drop
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  input beat last
- s_axis_tready  out  1  input ready
- m_axis_tvalid  out  1  output beat valid, towards the multiplexeur
- m_axis_tlast  out  1  output beat last
- m_axis_tready  in  1  downstream ready
- ctrl_valid  in  1  parser decision available (single-cycle pulse or level)
- ctrl_drop  in  1  parser decision: 1 = drop packet; sampled with ctrl_valid
- state  out  STATE_WIDTH  current state, registered
- pkt_count  out  CNT_WIDTH  packets completed via SEND_ANALYSED_DATA or SEND_REMAIN
- drop_count  out  CNT_WIDTH  packets dropped, including timeouts
- timeout_err  out  1  sticky; set when CONTROL times out

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; all counters=0; timeout_err=0; internal beat_cnt=0, ctrl_timer=0, pkt_ended=0.
- s_axis_tready, m_axis_tvalid and m_axis_tlast are combinational functions of the state and inputs. No output registering; zero latency.
- Accepted beat = s_axis_tvalid & s_axis_tready. Emitted beat = m_axis_tvalid & m_axis_tready.
- IDLE: tready=0, tvalid=0. If s_axis_tvalid=1, go to PARSE_DATA next cycle. Clear beat_cnt and pkt_ended.
- PARSE_DATA: tready=1.
  - Each accepted beat increments beat_cnt.
  - Go to CONTROL when an accepted beat has tlast=1 (set pkt_ended=1) or beat_cnt==HEADER_WORDS-1. Clear ctrl_timer on entry.
- CONTROL: tready=0, tvalid=0. ctrl_timer increments each cycle.
  - ctrl_valid & ctrl_drop: go to DROP.
  - ctrl_valid & !ctrl_drop: go to SEND_ANALYSED_DATA. Clear beat_cnt.
  - ctrl_timer==CONTROL_TIMEOUT-1 without ctrl_valid: set timeout_err, go to DROP.
  - ctrl_valid on the timeout cycle: ctrl_valid wins.
- SEND_ANALYSED_DATA: m_axis_tvalid=1, s_axis_tready=0. Each emitted beat increments beat_cnt.
  - m_axis_tlast=1 only on beat ANALYSED_WORDS-1 and only if pkt_ended=1.
  - After that beat: if pkt_ended, go to IDLE and pkt_count+1; else go to SEND_REMAIN.
  - tvalid must stay asserted while tready=0.
- SEND_REMAIN: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tlast=s_axis_tlast.
  - Emitted beat with tlast=1: go to IDLE, pkt_count+1.
- DROP: m_axis_tvalid=0.
  - If pkt_ended=1: tready=0, go to IDLE next cycle, drop_count+1.
  - Else: tready=1, discard beats; accepted tlast goes to IDLE, drop_count+1.
- Counters wrap at 2^CNT_WIDTH. A timeout drop increments drop_count once.
- ctrl_valid outside CONTROL is ignored.
- Undefined state encodings go to IDLE.
- Reset mid-packet: FSM returns to IDLE immediately. The remainder of the interrupted packet is treated as a new packet; no recovery is attempted.

Test Plan:
- HEADER_WORDS=4, ANALYSED_WORDS=2; 8-beat packet, ctrl_valid=1/drop=0 two cycles after CONTROL entry, tready=1 -> state sequence IDLE,PARSE(4 beats),CONTROL(3 cycles),SEND_ANALYSED(2 beats),SEND_REMAIN(4 beats, tlast on 4th); pkt_count=1.
- 2-beat packet (tlast on beat 2), accepted decision -> CONTROL after 2 beats; 2 analysed beats with tlast on the second; then IDLE; no SEND_REMAIN; pkt_count=1.
- 10-beat packet, ctrl_drop=1 -> DROP; 6 remaining beats accepted, m_axis_tvalid=0 throughout; drop_count=1; pkt_count=0.
- No ctrl_valid for 64 cycles -> timeout_err=1, DROP, drop_count=1. ctrl_valid on cycle 63 instead -> no timeout_err.
- m_axis_tready toggled 1/0 each cycle during SEND_ANALYSED_DATA and SEND_REMAIN -> tvalid held, no lost or duplicated beats; s_axis_tready mirrors m_axis_tready in SEND_REMAIN.
- rst_n pulsed low during SEND_REMAIN -> state=IDLE and counters=0 asynchronously; next packet processed normally.

Source files
------------

// File: rtl/axis_packet_dispatcher_fsm.sv
// Packet sequencer placed ahead of the dispatcher demultiplexer.
// Steers each AXI-Stream packet through header capture, the parser decision,
// emission of analysed words, pass-through of the remainder, or drop.
// Owns every s_axis/m_axis handshake qualifier; tdata is handled elsewhere.
//
// state              | meaning
// -------------------+-----------------------------------------------------
// IDLE               | waiting for the first beat of a packet
// PARSE_DATA         | header beats routed to the parser
// CONTROL            | waiting for the parser verdict, bounded by a timer
// SEND_ANALYSED_DATA | emitting the parser result words downstream
// SEND_REMAIN        | passing the rest of the packet straight through
// DROP               | discarding the rest of a rejected packet
module axis_packet_dispatcher_fsm #(
  parameter int STATE_WIDTH     = 3,
  parameter int HEADER_WORDS    = 4,
  parameter int ANALYSED_WORDS  = 2,
  parameter int CONTROL_TIMEOUT = 64,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  input  logic                   ctrl_valid,
  input  logic                   ctrl_drop,
  output logic [STATE_WIDTH-1:0] state,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic                   timeout_err
);

  // Encodings are shared with the demultiplexer and must not change.
  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE               = STATE_WIDTH'(0),
    PARSE_DATA         = STATE_WIDTH'(1),
    CONTROL            = STATE_WIDTH'(2),
    SEND_ANALYSED_DATA = STATE_WIDTH'(3),
    SEND_REMAIN        = STATE_WIDTH'(4),
    DROP               = STATE_WIDTH'(5)
  } state_t;

  // beat_cnt must hold one past the larger beat limit: PARSE_DATA still
  // increments on the beat that leaves the state.
  localparam int MAX_WORDS = (HEADER_WORDS > ANALYSED_WORDS) ? HEADER_WORDS : ANALYSED_WORDS;
  localparam int BW        = $clog2(MAX_WORDS + 1);
  localparam int TW        = $clog2(CONTROL_TIMEOUT + 1);

  localparam logic [BW-1:0] HDR_LAST = BW'(HEADER_WORDS - 1);
  localparam logic [BW-1:0] ANA_LAST = BW'(ANALYSED_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CONTROL_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pkt_ended_q, pkt_ended_d;
  logic            pkt_inc, drop_inc, tmo_set;

  assign state = state_q;

  // State register and per-packet bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      timer_q     <= '0;
      pkt_ended_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      timer_q     <= timer_d;
      pkt_ended_q <= pkt_ended_d;
    end
  end

  // Statistics counters (free-running, wrap naturally) and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count   <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (pkt_inc)  pkt_count  <= pkt_count + CNT_WIDTH'(1);
      if (drop_inc) drop_count <= drop_count + CNT_WIDTH'(1);
      if (tmo_set)  timeout_err <= 1'b1;
    end
  end

  // Next-state logic plus the unregistered handshake qualifiers.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    timer_d       = timer_q;
    pkt_ended_d   = pkt_ended_q;
    pkt_inc       = 1'b0;
    drop_inc      = 1'b0;
    tmo_set       = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;

    case (state_q)
      IDLE: begin
        beat_cnt_d  = '0;
        pkt_ended_d = 1'b0;
        if (s_axis_tvalid) state_d = PARSE_DATA;
      end

      PARSE_DATA: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (s_axis_tlast || (beat_cnt_q == HDR_LAST)) begin
            state_d     = CONTROL;
            timer_d     = '0;
            pkt_ended_d = s_axis_tlast;
          end
        end
      end

      CONTROL: begin
        timer_d = timer_q + TW'(1);
        // A verdict arriving on the timeout cycle still takes priority.
        if (ctrl_valid) begin
          if (ctrl_drop) begin
            state_d = DROP;
          end else begin
            state_d    = SEND_ANALYSED_DATA;
            beat_cnt_d = '0;
          end
        end else if (timer_q == TMO_LAST) begin
          tmo_set = 1'b1;
          state_d = DROP;
        end
      end

      SEND_ANALYSED_DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = pkt_ended_q && (beat_cnt_q == ANA_LAST);
        if (m_axis_tready) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == ANA_LAST) begin
            if (pkt_ended_q) begin
              state_d = IDLE;
              pkt_inc = 1'b1;
            end else begin
              state_d = SEND_REMAIN;
            end
          end
        end
      end

      SEND_REMAIN: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tlast  = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = IDLE;
          pkt_inc = 1'b1;
        end
      end

      DROP: begin
        // The packet may already have ended inside the header window.
        if (pkt_ended_q) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end else begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) begin
            state_d  = IDLE;
            drop_inc = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_packet_dispatcher_fsm.sv
// Scoreboard bench for axis_packet_dispatcher_fsm (HEADER_WORDS=4,
// ANALYSED_WORDS=2, CONTROL_TIMEOUT=64). Expected output beats are queued
// when a packet is issued; the monitor pops one per emitted beat.
module tb_axis_packet_dispatcher_fsm;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PARSE = 3'd1;
  localparam logic [2:0] S_CTRL  = 3'd2;
  localparam logic [2:0] S_SA    = 3'd3;
  localparam logic [2:0] S_SR    = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        ctrl_valid, ctrl_drop;
  logic [2:0]  state;
  logic [31:0] pkt_count, drop_count;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];   // {state, tlast} of each expected emitted beat
  logic       src_q[$];   // tlast of each pending source beat
  logic       toggle_mode = 1'b0;

  int parse_acc = 0, ctrl_cyc = 0, drop_acc = 0, sr_cyc = 0;
  int b_parse, b_ctrl, b_drop, b_sr;

  axis_packet_dispatcher_fsm #(
    .STATE_WIDTH(3), .HEADER_WORDS(4), .ANALYSED_WORDS(2),
    .CONTROL_TIMEOUT(64), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .ctrl_valid(ctrl_valid), .ctrl_drop(ctrl_drop),
    .state(state), .pkt_count(pkt_count), .drop_count(drop_count), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Source: presents queued beats, advances on an accepted handshake.
  initial begin : source
    logic acc;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      s_axis_tvalid = (src_q.size() > 0);
      s_axis_tlast  = (src_q.size() > 0) ? src_q[0] : 1'b0;
    end
  end

  // Sink: ready held high, or toggling every cycle when toggle_mode is set.
  initial begin : sink
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = toggle_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // Monitor: samples mid-cycle, scores emitted beats and protocol rules.
  initial begin : monitor
    logic       prev_stall;
    logic [3:0] e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL tvalid_hold: m_axis_tvalid=%0b required 1 at %0t", m_axis_tvalid, $time);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: state=%0d tlast=%0b emitted, no beat required at %0t",
                     state, m_axis_tlast, $time);
          end else begin
            e = exp_q.pop_front();
            if ({state, m_axis_tlast} !== e) begin
              errors++;
              $display("FAIL out_beat: state=%0d tlast=%0b required state=%0d tlast=%0b at %0t",
                       state, m_axis_tlast, e[3:1], e[0], $time);
            end
          end
        end
        if (state == S_DROP) begin
          checks++;
          if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drop_tvalid: m_axis_tvalid=%0b required 0 at %0t", m_axis_tvalid, $time);
          end
        end
        if (state == S_SR) begin
          checks++;
          if (s_axis_tready !== m_axis_tready) begin
            errors++;
            $display("FAIL remain_ready: s_axis_tready=%0b required %0b at %0t",
                     s_axis_tready, m_axis_tready, $time);
          end
          sr_cyc++;
        end
        if (state == S_CTRL) ctrl_cyc++;
        if (state == S_PARSE && s_axis_tvalid && s_axis_tready) parse_acc++;
        if (state == S_DROP && s_axis_tvalid && s_axis_tready) drop_acc++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state === tgt) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: state=%0d, required %0d within %0d cycles", name, state, tgt, budget);
    end
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(i == n - 1);
  endtask

  task automatic exp_beat(input logic [2:0] st, input logic last);
    exp_q.push_back({st, last});
  endtask

  // Called at the mid-cycle point of the first CONTROL cycle; asserts the
  // verdict for exactly one cycle, during CONTROL cycle number 'delay'.
  task automatic decide(input int delay, input logic drop);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
    end
    ctrl_valid = 1'b1;
    ctrl_drop  = drop;
    @(posedge clk);
    #1;
    ctrl_valid = 1'b0;
    ctrl_drop  = 1'b0;
  endtask

  task automatic snap();
    b_parse = parse_acc;
    b_ctrl  = ctrl_cyc;
    b_drop  = drop_acc;
    b_sr    = sr_cyc;
  endtask

  initial begin : main
    rst_n      = 1'b0;
    ctrl_valid = 1'b0;
    ctrl_drop  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_pkt_count", pkt_count, 0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_timeout_err", 32'(timeout_err), 0);
    chk("reset_s_tready", 32'(s_axis_tready), 0);
    chk("reset_m_tvalid", 32'(m_axis_tvalid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8-beat packet, accepted two cycles into CONTROL.
    snap();
    exp_beat(S_SA, 0); exp_beat(S_SA, 0);
    exp_beat(S_SR, 0); exp_beat(S_SR, 0); exp_beat(S_SR, 0); exp_beat(S_SR, 1);
    send_pkt(8);
    wait_state(S_CTRL, 20, "t1_reach_control");
    decide(2, 1'b0);
    wait_state(S_IDLE, 40, "t1_done");
    chk("t1_parse_beats", 32'(parse_acc - b_parse), 4);
    chk("t1_control_cycles", 32'(ctrl_cyc - b_ctrl), 3);
    chk("t1_remain_cycles", 32'(sr_cyc - b_sr), 4);
    chk("t1_pkt_count", pkt_count, 1);
    chk("t1_drop_count", drop_count, 0);
    chk("t1_beats_left", 32'(exp_q.size()), 0);

    // 2-beat packet ends inside the header window.
    snap();
    exp_beat(S_SA, 0); exp_beat(S_SA, 1);
    send_pkt(2);
    wait_state(S_CTRL, 20, "t2_reach_control");
    decide(0, 1'b0);
    wait_state(S_IDLE, 20, "t2_done");
    chk("t2_parse_beats", 32'(parse_acc - b_parse), 2);
    chk("t2_control_cycles", 32'(ctrl_cyc - b_ctrl), 1);
    chk("t2_remain_cycles", 32'(sr_cyc - b_sr), 0);
    chk("t2_pkt_count", pkt_count, 2);
    chk("t2_beats_left", 32'(exp_q.size()), 0);

    // 10-beat packet rejected by the parser.
    snap();
    send_pkt(10);
    wait_state(S_CTRL, 20, "t3_reach_control");
    decide(1, 1'b1);
    wait_state(S_IDLE, 40, "t3_done");
    chk("t3_parse_beats", 32'(parse_acc - b_parse), 4);
    chk("t3_drop_beats", 32'(drop_acc - b_drop), 6);
    chk("t3_drop_count", drop_count, 1);
    chk("t3_pkt_count", pkt_count, 2);

    // No verdict: timeout after 64 CONTROL cycles.
    snap();
    send_pkt(2);
    wait_state(S_CTRL, 20, "t4_reach_control");
    wait_state(S_IDLE, 150, "t4_done");
    chk("t4_control_cycles", 32'(ctrl_cyc - b_ctrl), 64);
    chk("t4_timeout_err", 32'(timeout_err), 1);
    chk("t4_drop_count", drop_count, 2);
    chk("t4_pkt_count", pkt_count, 2);

    // Back-pressure toggling during analysed and remainder phases.
    snap();
    toggle_mode = 1'b1;
    exp_beat(S_SA, 0); exp_beat(S_SA, 0);
    exp_beat(S_SR, 0); exp_beat(S_SR, 0); exp_beat(S_SR, 0); exp_beat(S_SR, 1);
    send_pkt(8);
    wait_state(S_CTRL, 20, "t5_reach_control");
    decide(1, 1'b0);
    wait_state(S_IDLE, 60, "t5_done");
    toggle_mode = 1'b0;
    chk("t5_pkt_count", pkt_count, 3);
    chk("t5_beats_left", 32'(exp_q.size()), 0);
    chk("t5_parse_beats", 32'(parse_acc - b_parse), 4);

    // Reset asserted mid-cycle while passing the remainder through.
    exp_beat(S_SA, 0); exp_beat(S_SA, 0);
    exp_beat(S_SR, 0); exp_beat(S_SR, 0); exp_beat(S_SR, 0); exp_beat(S_SR, 1);
    send_pkt(8);
    wait_state(S_CTRL, 20, "t6_reach_control");
    decide(0, 1'b0);
    wait_state(S_SR, 20, "t6_reach_remain");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 32'(S_IDLE));
    chk("t6_rst_pkt_count", pkt_count, 0);
    chk("t6_rst_drop_count", drop_count, 0);
    chk("t6_rst_timeout_err", 32'(timeout_err), 0);
    chk("t6_rst_s_tready", 32'(s_axis_tready), 0);
    exp_q.delete();
    src_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // After reset: verdict on the last CONTROL cycle beats the timeout.
    snap();
    exp_beat(S_SA, 0); exp_beat(S_SA, 1);
    send_pkt(2);
    wait_state(S_CTRL, 20, "t7_reach_control");
    decide(63, 1'b0);
    wait_state(S_IDLE, 20, "t7_done");
    chk("t7_control_cycles", 32'(ctrl_cyc - b_ctrl), 64);
    chk("t7_timeout_err", 32'(timeout_err), 0);
    chk("t7_pkt_count", pkt_count, 1);
    chk("t7_drop_count", drop_count, 0);
    chk("t7_beats_left", 32'(exp_q.size()), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
